inst_issue_queue: RTL and testbench

Parametrised multi-lane instruction buffer between the fetch stage and the decode/issue stage. It accepts up to WR_LANES instructions per cycle from fetch, compacts them into a circular store of DEPTH entries, and presents the oldest RD_LANES entries to issue. Issue consumes a variable count of 0..RD_LANES entries per cycle. The block has its own occupancy counter, full/empty flags and one-cycle flush, so fetch and issue are decoupled.

---
 rtl/inst_issue_queue.sv | 112 +++++++++++
 tb/tb_inst_issue_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// inst_issue_queue: multi-lane fetch-to-issue instruction buffer.
// Compacts up to WR_LANES valid fetch lanes per cycle into a circular store
// and presents the oldest RD_LANES entries to issue, which consumes 0..RD_LANES.
// Optional feature macro: IQ_DUAL_ISSUE_EN (undefined = single-issue dequeue).
module inst_issue_queue #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int WR_LANES = 2,
  parameter int RD_LANES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             branch_flush_i,
  input  logic                             excep_flush_i,
  input  logic [WR_LANES-1:0]              enq_valid_i,
  input  logic [WR_LANES*DATA_W-1:0]       enq_data_i,
  output logic                             allowin_o,
  output logic [RD_LANES-1:0]              deq_valid_o,
  output logic [RD_LANES*DATA_W-1:0]       deq_data_o,
  input  logic [$clog2(RD_LANES+1)-1:0]    deq_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]       count_o,
  output logic                             empty_o,
  output logic                             full_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DCNT_W = $clog2(RD_LANES + 1);
  localparam int WIDE_W = CNT_W + DCNT_W;
`ifdef IQ_DUAL_ISSUE_EN
  localparam int ISSUE_LANES = RD_LANES;
`else
  localparam int ISSUE_LANES = 1;
`endif

  logic [DATA_W-1:0] r_store [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_flush;
  logic              w_allowin;
  logic              w_doEnq;
  logic [CNT_W-1:0]  w_nWrRaw;
  logic [CNT_W-1:0]  w_nWr;
  logic [CNT_W-1:0]  w_nRd;
  logic [WIDE_W-1:0] w_rdReq;
  logic [PTR_W-1:0]  w_wrIdx [WR_LANES];

  assign w_flush   = branch_flush_i | excep_flush_i;
  // Space check uses only the registered count, so no same-cycle dequeue credit.
  assign w_allowin = (r_count <= CNT_W'(DEPTH - WR_LANES));
  assign w_doEnq   = w_allowin & (|enq_valid_i) & ~w_flush;
  assign w_nWr     = w_doEnq ? w_nWrRaw : '0;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    w_nWrRaw = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      w_wrIdx[k] = r_tail + PTR_W'(w_nWrRaw);
      w_nWrRaw   = w_nWrRaw + CNT_W'(enq_valid_i[k]);
    end
  end

  // Dequeue count is silently clipped to the issue width and to the occupancy.
  always_comb begin
    w_rdReq = WIDE_W'(deq_cnt_i);
    if (w_rdReq > WIDE_W'(ISSUE_LANES)) w_rdReq = WIDE_W'(ISSUE_LANES);
    if (w_rdReq > WIDE_W'(r_count))     w_rdReq = WIDE_W'(r_count);
    w_nRd = CNT_W'(w_rdReq);
  end

  // Entry store: zeroed on reset, left untouched by a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_store[i] <= '0;
    end else if (w_doEnq) begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (enq_valid_i[k]) r_store[w_wrIdx[k]] <= enq_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Pointers and occupancy; flush has reset priority and drops same-cycle traffic.
  always_ff @(posedge clk) begin
    if (!rst_n || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_nRd);
      r_tail  <= r_tail + PTR_W'(w_nWr);
      r_count <= r_count + w_nWr - w_nRd;
    end
  end

  // Issue view of the oldest entries, purely from registered state.
  always_comb begin
    deq_valid_o = '0;
    deq_data_o  = '0;
    for (int k = 0; k < RD_LANES; k++) begin
      deq_valid_o[k] = (k < ISSUE_LANES) && (r_count > CNT_W'(k));
      deq_data_o[k*DATA_W +: DATA_W] = r_store[r_head + PTR_W'(k)];
    end
  end

  assign allowin_o = w_allowin;
  assign count_o   = r_count;
  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed, table-driven bench for inst_issue_queue (DEPTH=8, WR=RD=2).
module tb_inst_issue_queue;

  localparam int DATA_W   = 64;
  localparam int DEPTH    = 8;
  localparam int WR_LANES = 2;
  localparam int RD_LANES = 2;
`ifdef IQ_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        branch_flush_i;
  logic                        excep_flush_i;
  logic [WR_LANES-1:0]         enq_valid_i;
  logic [WR_LANES*DATA_W-1:0]  enq_data_i;
  logic                        allowin_o;
  logic [RD_LANES-1:0]         deq_valid_o;
  logic [RD_LANES*DATA_W-1:0]  deq_data_o;
  logic [1:0]                  deq_cnt_i;
  logic [3:0]                  count_o;
  logic                        empty_o;
  logic                        full_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  enqValid;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  deqCnt;
    logic        bFlush;
    logic        eFlush;
    int          expCount;
    logic        expAllow;
    logic [63:0] expD0;
    logic [63:0] expD1;
    bit          chkData;
  } vec_t;

  vec_t vecs[$];

  inst_issue_queue #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .WR_LANES(WR_LANES), .RD_LANES(RD_LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_flush_i(branch_flush_i), .excep_flush_i(excep_flush_i),
    .enq_valid_i(enq_valid_i), .enq_data_i(enq_data_i),
    .allowin_o(allowin_o), .deq_valid_o(deq_valid_o), .deq_data_o(deq_data_o),
    .deq_cnt_i(deq_cnt_i), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] expValidOf(input int c);
    logic [1:0] r;
    r[0] = (c > 0);
    r[1] = DUAL ? (c > 1) : 1'b0;
    return r;
  endfunction

  task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addVec(input string nm, input logic [1:0] ev, input logic [63:0] d0,
                        input logic [63:0] d1, input logic [1:0] dc, input logic bf,
                        input logic ef, input int ec, input logic ea,
                        input logic [63:0] e0, input logic [63:0] e1, input bit cd);
    vec_t v;
    v.name = nm; v.enqValid = ev; v.d0 = d0; v.d1 = d1; v.deqCnt = dc;
    v.bFlush = bf; v.eFlush = ef; v.expCount = ec; v.expAllow = ea;
    v.expD0 = e0; v.expD1 = e1; v.chkData = cd;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [1:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                               input logic [1:0] dc, input logic bf, input logic ef);
    enq_valid_i    = ev;
    enq_data_i     = {d1, d0};
    deq_cnt_i      = dc;
    branch_flush_i = bf;
    excep_flush_i  = ef;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input int ec, input logic ea,
                             input logic [63:0] e0, input logic [63:0] e1, input bit cd);
    logic [1:0] ev;
    ev = expValidOf(ec);
    checkVal({nm, ".count"},   64'(count_o), 64'(ec));
    checkVal({nm, ".valid"},   64'(deq_valid_o), 64'(ev));
    checkVal({nm, ".allowin"}, 64'(allowin_o), 64'(ea));
    checkVal({nm, ".empty"},   64'(empty_o), 64'(ec == 0));
    checkVal({nm, ".full"},    64'(full_o), 64'(ec == DEPTH));
    if (cd && ev[0]) checkVal({nm, ".data0"}, deq_data_o[63:0], e0);
    if (cd && ev[1]) checkVal({nm, ".data1"}, deq_data_o[127:64], e1);
  endtask

  initial begin
    logic [63:0] seq [13];
    int expCnt;
    logic [63:0] expHead;

    // Table: enqValid, d0, d1, deqCnt, bFlush, eFlush, expCount, expAllow, expD0, expD1, chkData
    addVec("enqAB",       2'b11, 64'hA,   64'hB,   2'd0, 0, 0, 2, 1, 64'hA,  64'hB, 1);
    addVec("enqCD",       2'b11, 64'hC,   64'hD,   2'd0, 0, 0, 4, 1, 64'hA,  64'hB, 1);
    addVec("enq6",        2'b11, 64'h11,  64'h12,  2'd0, 0, 0, 6, 1, 64'hA,  64'hB, 1);
    addVec("fill8",       2'b11, 64'h13,  64'h14,  2'd0, 0, 0, 8, 0, 64'hA,  64'hB, 1);
    addVec("fullIgnore",  2'b11, 64'hE,   64'hF,   2'd0, 0, 0, 8, 0, 64'hA,  64'hB, 1);
    addVec("deq1",        2'b00, 64'h0,   64'h0,   2'd1, 0, 0, 7, 0, 64'hB,  64'hC, 1);
    addVec("noCredit",    2'b11, 64'h21,  64'h22,  2'd1, 0, 0, 6, 1, 64'hC,  64'hD, 1);
    addVec("branchFlush", 2'b11, 64'h31,  64'h32,  2'd1, 1, 0, 0, 1, 64'h0,  64'h0, 0);
    addVec("gapLane1",    2'b10, 64'hBAD, 64'h58,  2'd0, 0, 0, 1, 1, 64'h58, 64'h0, 1);
    addVec("clipToCount", 2'b00, 64'h0,   64'h0,   2'd2, 0, 0, 0, 1, 64'h0,  64'h0, 0);
    addVec("gapLane0",    2'b01, 64'h4B,  64'hBAD, 2'd0, 0, 0, 1, 1, 64'h4B, 64'h0, 1);

    rst_n = 1'b0;
    enq_valid_i = '0; enq_data_i = '0; deq_cnt_i = '0;
    branch_flush_i = 1'b0; excep_flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset", 0, 1, 64'h0, 64'h0, 0);
    checkVal("reset.data", 64'(deq_data_o != '0), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].enqValid, vecs[i].d0, vecs[i].d1, vecs[i].deqCnt,
                    vecs[i].bFlush, vecs[i].eFlush);
      checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expAllow,
                  vecs[i].expD0, vecs[i].expD1, vecs[i].chkData);
    end

    // Wrap: one in, one out at count 3 moves both pointers across 7 -> 0.
    $display("[TB] wrap sequence");
    seq[0] = 64'h4B; seq[1] = 64'h61; seq[2] = 64'h62;
    for (int j = 0; j < 10; j++) seq[3+j] = 64'h100 + 64'(j);
    applyStimulus(2'b11, 64'h61, 64'h62, 2'd0, 0, 0);
    checkOutput("wrapSetup", 3, 1, seq[0], seq[1], 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b01, seq[3+i], 64'hBAD, 2'd1, 0, 0);
      checkOutput($sformatf("wrap%0d", i), 3, 1, seq[i+1], seq[i+2], 1);
    end

    // Issue-width clip: request 2 with 4 entries held.
    $display("[TB] issue width clip");
    applyStimulus(2'b00, 64'h0, 64'h0, 2'd0, 0, 1);
    checkOutput("excepFlush", 0, 1, 64'h0, 64'h0, 0);
    applyStimulus(2'b11, 64'h70, 64'h71, 2'd0, 0, 0);
    checkOutput("clipFill1", 2, 1, 64'h70, 64'h71, 1);
    applyStimulus(2'b11, 64'h72, 64'h73, 2'd0, 0, 0);
    checkOutput("clipFill2", 4, 1, 64'h70, 64'h71, 1);
    expCnt  = DUAL ? 2 : 3;
    expHead = DUAL ? 64'h72 : 64'h71;
    applyStimulus(2'b00, 64'h0, 64'h0, 2'd2, 0, 0);
    checkOutput("clipWidth", expCnt, 1, expHead, expHead + 64'h1, 1);

    // Mid-stream reset with an enqueue in flight clears state and the store.
    $display("[TB] mid-stream reset");
    rst_n = 1'b0;
    applyStimulus(2'b11, 64'h80, 64'h81, 2'd1, 0, 0);
    checkOutput("midReset", 0, 1, 64'h0, 64'h0, 0);
    checkVal("midReset.data", deq_data_o[127:64] | deq_data_o[63:0], 64'h0);
    rst_n = 1'b1;
    applyStimulus(2'b01, 64'h90, 64'h0, 2'd0, 0, 0);
    checkOutput("postReset", 1, 1, 64'h90, 64'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
